// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: core/loader arbiter and sequencer for the shared memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed core priority.
module mem_port_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ready,
    output logic [DW-1:0] rdata,
    output logic          owner,
    output logic          busy,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    state_t        state, state_n;
    logic [3:0]    cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          grant;
    logic          win;
    assign grant = (state == IDLE) && (c_req || l_req);
`ifdef ARB_ROUND_ROBIN_EN
    logic last;
    // Pointer starts at loader so the core wins the first contention.
    assign win = (c_req && l_req) ? ~last : l_req;
    always_ff @(posedge clk or negedge rst)
        if (!rst) last <= 1'b1;
        else if (grant) last <= win;
`else
    assign win = ~c_req;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = IDLE;
        state_n = (state == IDLE) ? (grant ? BUSY : IDLE) :
                  (state == BUSY) ? ((cnt == 4'd0) ? RESP : BUSY) : IDLE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt     <= '0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (grant) begin
                cnt     <= 4'(WAIT);
                owner   <= win;
                we_q    <= win ? l_we : c_we;
                addr_q  <= win ? l_addr : c_addr;
                wdata_q <= win ? l_wdata : c_wdata;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == BUSY && cnt == 4'd0) rdata <= m_rdata;
        end
    always_comb begin
        m_en    = (state == BUSY);
        m_we    = (state == BUSY) && we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        c_ready = (state == RESP) && !owner;
        l_ready = (state == RESP) && owner;
        busy    = (state == BUSY) || (state == RESP);
    end
endmodule
